// File: rtl/clip_recorder.sv
// Single-clip record/loop-playback buffer for the 12 kHz decimated audio stream.
// Optional echo output enabled by defining CLIP_RECORDER_ECHO_EN.
module clip_recorder #(
   parameter int DEPTH      = 16384,
   parameter int ECHO_DELAY = 1500
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               record_in,
   input  logic               audio_valid_in,
   input  logic signed [15:0] audio_in,
   output logic               playing_out,
   output logic               full_out,
   output logic               sample_valid_out,
   output logic signed [15:0] single_out
`ifdef CLIP_RECORDER_ECHO_EN
   ,output logic signed [15:0] echo_out
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;

   state_t             state;
   logic [AW:0]        len;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               vld_p0, vld_p1;
   logic [AW-1:0]      addr_p0;
   logic signed [15:0] data_p1;
   logic signed [15:0] mem [DEPTH];

   logic wr_en, rd_en, last_rd;
   assign wr_en   = (state == RECORD) && record_in && audio_valid_in && (len < DEPTH_L);
   assign rd_en   = (state == PLAY) && !record_in && audio_valid_in;
   assign last_rd = (({1'b0, rd_ptr} + 1'b1) == len);

`ifdef CLIP_RECORDER_ECHO_EN
   localparam logic [AW:0]   ED_L  = (AW+1)'(ECHO_DELAY);
   localparam logic [AW+1:0] ED_L2 = (AW+2)'(ECHO_DELAY);

   logic               first_pass;
   logic [AW+1:0]      tap_sum, tap_wrap;
   logic [AW-1:0]      tap_addr, tap_addr_p0;
   logic               tap_en, tap_en_p0, tap_en_p1;
   logic signed [15:0] tap_p1;
   logic signed [16:0] echo_sum_p1;

   // Tap index modulo len without a divider; the range is below 2*len whenever the tap is used.
   assign tap_sum  = {2'b00, rd_ptr} + {1'b0, len} - ED_L2;
   assign tap_wrap = (tap_sum >= {1'b0, len}) ? tap_sum - {1'b0, len} : tap_sum;
   assign tap_addr = AW'(tap_wrap);
   assign tap_en   = (len > ED_L) && !(first_pass && ({1'b0, rd_ptr} < ED_L));

   assign echo_sum_p1 = $signed({data_p1[15], data_p1}) +
                        (tap_en_p1 ? $signed({{2{tap_p1[15]}}, tap_p1[15:1]}) : 17'sd0);

   function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
      if (x > 17'sd32767)
         return 16'sh7FFF;
      else if (x < -17'sd32768)
         return 16'sh8000;
      else
         return x[15:0];
   endfunction
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state            <= IDLE;
         len              <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         full_out         <= 1'b0;
         playing_out      <= 1'b0;
         vld_p0           <= 1'b0;
         vld_p1           <= 1'b0;
         sample_valid_out <= 1'b0;
         single_out       <= '0;
`ifdef CLIP_RECORDER_ECHO_EN
         echo_out         <= '0;
         first_pass       <= 1'b1;
`endif
      end else begin
         // p0: address issued, p1: RAM data, output register
         vld_p0           <= rd_en;
         vld_p1           <= vld_p0;
         sample_valid_out <= vld_p1;
         if (vld_p1) begin
            single_out <= data_p1;
`ifdef CLIP_RECORDER_ECHO_EN
            echo_out   <= sat16(echo_sum_p1);
`endif
         end
         case (state)
            IDLE: begin
               if (record_in) begin
                  state    <= RECORD;
                  wr_ptr   <= '0;
                  len      <= '0;
                  full_out <= 1'b0;
               end
            end
            RECORD: begin
               if (!record_in) begin
                  if (len != '0) begin
                     state       <= PLAY;
                     rd_ptr      <= '0;
                     playing_out <= 1'b1;
`ifdef CLIP_RECORDER_ECHO_EN
                     first_pass  <= 1'b1;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end else if (wr_en) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  len    <= len + 1'b1;
                  if ((len + 1'b1) == DEPTH_L)
                     full_out <= 1'b1;
               end
            end
            PLAY: begin
               if (record_in) begin
                  state       <= RECORD;
                  playing_out <= 1'b0;
                  wr_ptr      <= '0;
                  len         <= '0;
                  full_out    <= 1'b0;
               end else if (audio_valid_in) begin
                  rd_ptr <= last_rd ? '0 : rd_ptr + 1'b1;
`ifdef CLIP_RECORDER_ECHO_EN
                  if (last_rd)
                     first_pass <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (wr_en)
         mem[wr_ptr] <= audio_in;
      if (rd_en)
         addr_p0 <= rd_ptr;
      data_p1 <= mem[addr_p0];
`ifdef CLIP_RECORDER_ECHO_EN
      if (rd_en) begin
         tap_addr_p0 <= tap_addr;
         tap_en_p0   <= tap_en;
      end
      tap_p1    <= mem[tap_addr_p0];
      tap_en_p1 <= tap_en_p0;
`endif
   end

endmodule
